// File: rtl/clap_round_if.sv
// Bus between the round sequencer and the game / clap counter.
// master drives start, clap, target and the live count; slave is the sequencer.
interface clap_round_if;
  logic        start;
  logic        clap;
  logic [16:0] target;
  logic [16:0] count;
  logic        cnt_go;
  logic        cnt_en;
  logic [16:0] captured;
  logic        hit;
  logic        miss;
  logic [2:0]  score;
  logic [2:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output start, clap, target, count,
    input  cnt_go, cnt_en, captured, hit, miss, score, round, busy, done
  );

  modport slave (
    input  start, clap, target, count,
    output cnt_go, cnt_en, captured, hit, miss, score, round, busy, done
  );
endinterface

// File: rtl/clap_round_ctrl.sv
// Round sequencer for the reaction-timing clap counter: arms the counter,
// captures the count at a clap edge or timeout, judges it and keeps score.
//
// state  | meaning
// IDLE   | waiting for start after reset
// ARM    | one-cycle counter restart (cnt_go)
// LISTEN | counter running, waiting for clap edge or terminal count
// JUDGE  | compare captured against target, pulse hit/miss, bump round
// DONE   | game over, score/captured held until next start
module clap_round_ctrl #(
  parameter logic [16:0] MAXCOUNT = 17'd66080,
  parameter logic [16:0] WINDOW   = 17'd2000,
  parameter logic [2:0]  ROUNDS   = 3'd4
) (
  input logic         clk,
  input logic         reset,
  clap_round_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, LISTEN, JUDGE, DONE} state_t;

  state_t      state;
  logic        clap_q;
  logic        timed_out;
  logic [16:0] captured;
  logic [2:0]  score;
  logic [2:0]  round;
  logic [17:0] diff;
  logic        in_window;
  logic        clap_edge;
  logic [2:0]  round_nxt;

  assign clap_edge = bus.clap & ~clap_q;
  assign round_nxt = round + 3'd1;

  // 18-bit magnitude so a target above captured never wraps into a hit
  always_comb begin
    diff = 18'd0;
    if (captured >= bus.target)
      diff = {1'b0, captured} - {1'b0, bus.target};
    else
      diff = {1'b0, bus.target} - {1'b0, captured};
  end

  assign in_window = ~timed_out && (diff <= {1'b0, WINDOW});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clap_q    <= 1'b0;
      timed_out <= 1'b0;
      captured  <= '0;
      score     <= '0;
      round     <= '0;
    end else begin
      clap_q <= bus.clap;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            score     <= '0;
            round     <= '0;
            captured  <= '0;
            timed_out <= 1'b0;
            state     <= ARM;
          end
        end
        ARM: state <= LISTEN;
        LISTEN: begin
          // a clap in the terminal-count cycle still counts as a real clap
          if (clap_edge) begin
            captured  <= bus.count;
            timed_out <= 1'b0;
            state     <= JUDGE;
          end else if (bus.count == MAXCOUNT) begin
            captured  <= MAXCOUNT;
            timed_out <= 1'b1;
            state     <= JUDGE;
          end
        end
        JUDGE: begin
          if (in_window) score <= score + 3'd1;
          round <= round_nxt;
          state <= (round_nxt == ROUNDS) ? DONE : ARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cnt_go   = (state == ARM);
  assign bus.cnt_en   = (state == LISTEN);
  assign bus.busy     = (state == ARM) || (state == LISTEN) || (state == JUDGE);
  assign bus.done     = (state == DONE);
  assign bus.hit      = (state == JUDGE) && in_window;
  assign bus.miss     = (state == JUDGE) && ~in_window;
  assign bus.captured = captured;
  assign bus.score    = score;
  assign bus.round    = round;

endmodule

// File: doc/clap_round_ctrl.md
# clap_round_ctrl

Round sequencer for the clap counter in the reaction-timing game. Runs a fixed number of rounds: each round restarts the 17-bit clap counter, lets it count while listening for a clap, captures the count at the clap's rising edge (or at timeout), and judges it against a target window. It keeps a running score and flags completion to the display and game logic.

## Interface
- MAXCOUNT, 17'd66080, counter terminal value; must equal the counter's own MAXCOUNT
- WINDOW, 17'd2000, max |captured − target| scored as a hit
- ROUNDS, 3'd4, rounds per game; legal range 1..7
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  begin game; sampled in IDLE and DONE only
- clap  in  1  clap level, already synchronous to clk
- target  in  17  per-round target count, sampled in JUDGE
- count  in  17  live value from the clap counter
- cnt_go  out  1  counter restart; high for exactly the ARM cycle
- cnt_en  out  1  counter enable; high throughout LISTEN only
- captured  out  17  count latched at clap edge or timeout
- hit  out  1  one-cycle pulse, round judged in window
- miss  out  1  one-cycle pulse, round judged out of window or timed out
- score  out  3  hits this game
- round  out  3  completed rounds this game
- busy  out  1  high in ARM, LISTEN, JUDGE
- done  out  1  high in DONE

## Operation
- States: IDLE, ARM, LISTEN, JUDGE, DONE. State register is async-reset to IDLE.
- IDLE: if start, clear score, round, captured, and timeout flag; go to ARM.
- ARM: cnt_go=1 for one cycle; go to LISTEN.
- LISTEN: cnt_en=1. clap_q is clap registered every cycle; clap_edge = clap & ~clap_q.
  - On clap_edge: captured<=count, timeout flag<=0, go to JUDGE.
  - Else if count==MAXCOUNT: captured<=MAXCOUNT, timeout flag<=1, go to JUDGE.
  - If both occur in the same cycle, the clap wins and is judged normally.
- JUDGE: diff = |captured − target|, computed in 18 bits with no wrap.
  - hit=1 and score+1 if the timeout flag is clear and diff <= WINDOW; else miss=1.
  - round<=round+1.
  - Go to DONE if round+1==ROUNDS, else to ARM.
- DONE: done=1; score and captured are held. start begins a new game the same way IDLE does.
- start in ARM, LISTEN, or JUDGE is ignored.
- clap held high on entry to LISTEN produces no edge. It must fall and rise again.
- cnt_go, cnt_en, hit, miss, busy, and done are decoded from the state register and timeout/compare logic only. They never depend on start, clap, or count in the same cycle.
- Reset values: all outputs 0; clap_q 0; state IDLE. Reset asserted mid-round aborts the round immediately. The counter is not reset but is idle because cnt_en=0.

## Timing
- start high at edge T → ARM during cycle T+1 (cnt_go=1) → LISTEN from T+2.
- The counter reads 0 in the first LISTEN cycle and increments once per LISTEN cycle.
- Clap edge seen in the cycle where count=N → captured=N and JUDGE in the next cycle. hit/miss pulses in that JUDGE cycle. score and round update at the end of JUDGE.
- Clap-edge-to-judgement latency: 1 cycle. Round-to-round gap: JUDGE + ARM = 2 cycles before counting resumes.
- Timeout: JUDGE follows the cycle in which count==MAXCOUNT was seen. The counter has paused itself by then.
- The last JUDGE transitions to DONE; done rises one cycle after the final hit/miss pulse.

## Test plan
- Reset mid-LISTEN (bench uses MAXCOUNT=100, WINDOW=5, ROUNDS=3) → next cycle: state IDLE; cnt_en, busy, score, round all 0.
- start, target=20, clap rises at count=22 → captured=22, hit pulse 1 cycle, score=1, round=1, cnt_go pulses again one cycle later.
- target=20, clap rises at count=30 → captured=30, miss pulse, score unchanged.
- No clap for a round → captured=100, miss pulse, timeout flag set; target=98 still judged a miss.
- Clap edge in the same cycle count reaches 100 with target=100 → judged a hit, captured=100.
- Full 3-round game with 2 hits: done=1, score=2, round=3. start in LISTEN ignored. start in DONE clears score and round and pulses cnt_go.
